// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
// Request/response bundle for seq_alu.
//   start_i  : request strobe, sampled only while the ALU is idle
//   ctrl_i   : 4-bit operation code
//   src1_i   : operand A (WIDTH bits)
//   src2_i   : operand B (WIDTH bits)
//   result_o : registered result
//   zero_o   : registered, high when result_o is all zeros
//   ovf_o    : registered signed overflow (ADD/SUB only)
//   busy_o   : high while an operation is in flight
//   done_o   : one-cycle pulse, outputs valid from this cycle on
// The master modport is the requester side, slave is the ALU side.
// -----------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             ovf_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, ctrl_i, src1_i, src2_i,
        input  result_o, zero_o, ovf_o, busy_o, done_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i,
        output result_o, zero_o, ovf_o, busy_o, done_o
    );
endinterface

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Sequential ALU. Logic/arithmetic/shift/compare ops complete with a latency of
// one cycle; MULLO, DIVU and REMU iterate one bit per cycle for WIDTH cycles.
// Ports:
//   clk_i : clock, all state updates on the rising edge
//   rst_i : asynchronous active-low reset
//   bus   : seq_alu_if.slave (start/ctrl/src1/src2 in, result/zero/ovf/busy/done out)
// Opcodes: 0 AND, 1 OR, 2 ADD, 3 MULLO, 4 DIVU, 5 REMU, 6 SUB, 7 SLTU,
//          8 SLL, 9 SRL, 10 SRA, 12 NOR, 13 SLT; anything else yields 0.
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    seq_alu_if.slave bus
);
    localparam int SH = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIVU = 4'd4;
    localparam logic [3:0] OP_REMU = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_SLT  = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched request. For the iterative ops a_q/b_q double as working
    // registers: MULLO shifts the multiplicand left in a_q and the multiplier
    // right in b_q; DIVU/REMU shift the dividend out of a_q while quotient bits
    // shift in, and b_q holds the divisor.
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;   // MULLO partial product / DIVU-REMU remainder
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             done_q;

    logic             accept;
    logic             iter_req;
    logic             last_iter;

    assign accept    = (state_q == IDLE) && bus.start_i;
    assign iter_req  = (bus.ctrl_i == OP_MUL) || (bus.ctrl_i == OP_DIVU) ||
                       (bus.ctrl_i == OP_REMU);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = iter_req ? CALC : DONE;
            CALC:    if (last_iter)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------ divider step
    // Restoring division: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The remainder is always below the
    // divisor, so WIDTH bits of difference are enough. A zero divisor always
    // "fits", which naturally yields an all-ones quotient and a remainder
    // equal to the dividend.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;

    assign rem_sh  = {acc_q, a_q[WIDTH-1]};
    assign rem_ge  = rem_sh >= {1'b0, b_q};
    assign rem_sub = rem_sh[WIDTH-1:0] - b_q;

    // --------------------------------------------------------- datapath
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            op_q  <= bus.ctrl_i;
            a_q   <= bus.src1_i;
            b_q   <= bus.src2_i;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + CW'(1);
            if (op_q == OP_MUL) begin
                if (b_q[0]) acc_q <= acc_q + a_q;
                a_q <= a_q << 1;
                b_q <= b_q >> 1;
            end else begin
                acc_q <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                a_q   <= {a_q[WIDTH-2:0], rem_ge};
            end
        end
    end

    // ------------------------------------------------ result selection
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [SH-1:0]    shamt;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;

    assign sum   = a_q + b_q;
    assign dif   = a_q - b_q;
    assign shamt = b_q[SH-1:0];

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (op_q)
            OP_AND:  res_d = a_q & b_q;
            OP_OR:   res_d = a_q | b_q;
            OP_NOR:  res_d = ~(a_q | b_q);
            OP_ADD: begin
                res_d = sum;
                ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = dif;
                ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                        (dif[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLL:  res_d = a_q << shamt;
            OP_SRL:  res_d = a_q >> shamt;
            OP_SRA:  res_d = $signed(a_q) >>> shamt;
            OP_MUL:  res_d = acc_q;
            OP_DIVU: res_d = a_q;     // quotient has fully replaced the dividend
            OP_REMU: res_d = acc_q;
            default: res_d = '0;
        endcase
    end

    // Outputs only update in DONE, so iteration values never leak out.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (state_q == DONE) begin
                result_q <= res_d;
                zero_q   <= (res_d == '0);
                ovf_q    <= ovf_d;
            end
        end
    end

    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.done_o   = done_q;
    assign bus.busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Random and directed stimulus for seq_alu. Each accepted request pushes its
// expected result, flags and completion cycle into a scoreboard; a monitor
// pops and compares whenever done_o is seen.
// -----------------------------------------------------------------------------
module tb_seq_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_alu_if #(.WIDTH(W)) bus();

    seq_alu #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         o;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model written straight from the opcode definitions.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic o);
        longint sa, sb_, s;
        logic [63:0] p;
        logic signed [W-1:0] as_;
        logic [4:0] sh;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        as_ = a;
        sh  = b[4:0];
        r = '0;
        o = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin r = a + b; s = sa + sb_; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd6:  begin r = a - b; s = sa - sb_; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd7:  r = (a < b) ? 32'd1 : 32'd0;
            4'd12: r = ~(a | b);
            4'd13: r = (sa < sb_) ? 32'd1 : 32'd0;
            4'd8:  r = a << sh;
            4'd9:  r = a >> sh;
            4'd10: r = as_ >>> sh;
            4'd3:  begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            4'd4:  r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd5:  r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
    endfunction

    // Monitor: every done_o pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus.done_o) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done_o=1, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_result"}, 64'(bus.result_o), 64'(mon_e.r));
                chk({mon_e.name, "_zero"},   64'(bus.zero_o),   64'(mon_e.z));
                chk({mon_e.name, "_ovf"},    64'(bus.ovf_o),    64'(mon_e.o));
                chk({mon_e.name, "_cycle"},  64'(cyc),          64'(mon_e.cyc));
            end
        end
    end

    // Issue one request once the ALU is idle. Returns at the falling edge after
    // acceptance. With hold set, start_i stays high (with changing operands)
    // until busy_o drops, which must not cause a second acceptance.
    task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit hold);
        int n;
        int lat;
        logic [W-1:0] r;
        logic o;
        exp_t e;
        lat = (op == 4'd3 || op == 4'd4 || op == 4'd5) ? W + 1 : 1;
        @(negedge clk);
        n = 0;
        while (bus.busy_o && n < 200) begin @(negedge clk); n++; end
        if (bus.busy_o) chk({name, "_idle_timeout"}, 64'(bus.busy_o), 64'd0);
        bus.start_i = 1'b1;
        bus.ctrl_i  = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        @(posedge clk);
        #1;
        model(op, a, b, r, o);
        e.r = r; e.z = (r == '0); e.o = o; e.cyc = cyc + lat; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        bus.src1_i = $urandom;
        bus.src2_i = $urandom;
        if (!hold) begin
            bus.start_i = 1'b0;
            bus.ctrl_i  = 4'($urandom);
        end else begin
            n = 0;
            while (bus.busy_o && n < 200) begin
                @(negedge clk);
                bus.src1_i = $urandom;
                bus.src2_i = $urandom;
                n++;
            end
            bus.start_i = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (sb.size() != 0) chk({name, "_drain_timeout"}, 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h7FFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'($urandom_range(0, 40));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int nb;
        bus.start_i = 1'b0;
        bus.ctrl_i  = '0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_result", 64'(bus.result_o), 64'd0);
        chk("rst_zero",   64'(bus.zero_o),   64'd1);
        chk("rst_ovf",    64'(bus.ovf_o),    64'd0);
        chk("rst_busy",   64'(bus.busy_o),   64'd0);
        chk("rst_done",   64'(bus.done_o),   64'd0);
        rst_n = 1'b1;

        // Directed corners
        issue("add_ovf",   4'd2,  32'h7FFF_FFFF, 32'd1, 1'b0);
        issue("slt",       4'd13, 32'hFFFF_FFFF, 32'd1, 1'b0);
        issue("sltu",      4'd7,  32'hFFFF_FFFF, 32'd1, 1'b0);
        issue("sub_zero",  4'd6,  32'd5, 32'd5, 1'b0);
        issue("sra",       4'd10, 32'h8000_0000, 32'h21, 1'b0);
        issue("op15",      4'd15, 32'h1234_5678, 32'h9, 1'b0);
        issue("sub_ovf",   4'd6,  32'h8000_0000, 32'd1, 1'b0);
        issue("mullo",     4'd3,  32'h0001_0000, 32'h0001_0001, 1'b0);
        nb = 0;
        while (bus.busy_o && nb < 100) begin nb++; @(negedge clk); end
        chk("mullo_busy_cycles", 64'(nb), 64'd33);
        issue("divu",      4'd4,  32'd100, 32'd7, 1'b0);
        issue("remu",      4'd5,  32'd100, 32'd7, 1'b0);
        issue("divu_by0",  4'd4,  32'hDEAD_BEEF, 32'd0, 1'b0);
        issue("remu_by0",  4'd5,  32'd9, 32'd0, 1'b0);
        issue("divu_hold", 4'd4,  32'hFFFF_FFF0, 32'd3, 1'b1);
        drain("directed");

        // Reset in the middle of an iterative op
        issue("divu_abort", 4'd4, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("abort_result", 64'(bus.result_o), 64'd0);
        chk("abort_zero",   64'(bus.zero_o),   64'd1);
        chk("abort_ovf",    64'(bus.ovf_o),    64'd0);
        chk("abort_busy",   64'(bus.busy_o),   64'd0);
        chk("abort_done",   64'(bus.done_o),   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue("add_after_rst", 4'd2, 32'd40, 32'd2, 1'b0);
        drain("abort");

        // Random mix, all 16 opcodes
        for (int i = 0; i < 150; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            issue($sformatf("rnd%0d_op%0d", i, op), op, pick_operand(), pick_operand(),
                  ($urandom_range(0, 9) == 0));
        end
        drain("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
